// File: rtl/hazard_ctrl.sv
// Stall and forwarding control for the five-stage MIPS pipeline.
// Tracks destination register and remaining result latency for E, M and W.
module hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       addu,
  input  logic       subu,
  input  logic       slt,
  input  logic       ori,
  input  logic       addi,
  input  logic       addiu,
  input  logic       lui,
  input  logic       lw,
  input  logic       sw,
  input  logic       beq,
  input  logic       j,
  input  logic       jal,
  input  logic       jr,
  input  logic [4:0] A1_ID,
  input  logic [4:0] A2_ID,
  input  logic [4:0] A3_ID,
  output logic       stall,
  output logic [1:0] fwd_rs_ID,
  output logic [1:0] fwd_rt_ID,
  output logic [1:0] fwd_rs_E,
  output logic [1:0] fwd_rt_E,
  output logic       fwd_rt_M
);

  logic [4:0] e_a1_q, e_a2_q, e_a3_q, m_a2_q, m_a3_q, w_a3_q;
  logic [4:0] e_a1_d, e_a2_d, e_a3_d, m_a2_d, m_a3_d, w_a3_d;
  logic [1:0] e_tnew_q, m_tnew_q, e_tnew_d, m_tnew_d;

  logic       alu_op, writes;
  logic       rs_used, rt_used;
  logic [1:0] rs_tuse, rt_tuse, id_tnew;
  logic [4:0] id_a3;

  assign alu_op = addu | subu | slt | ori | addi | addiu | lui;
  assign writes = alu_op | lw | jal;

  always_comb begin
    rs_used = 1'b0;
    rs_tuse = 2'd0;
    rt_used = 1'b0;
    rt_tuse = 2'd0;
    if (beq) begin
      rs_used = 1'b1;
      rt_used = 1'b1;
    end else if (jr) begin
      rs_used = 1'b1;
    end else if (addu | subu | slt) begin
      rs_used = 1'b1; rs_tuse = 2'd1;
      rt_used = 1'b1; rt_tuse = 2'd1;
    end else if (ori | addi | addiu | lw) begin
      rs_used = 1'b1; rs_tuse = 2'd1;
    end else if (sw) begin
      rs_used = 1'b1; rs_tuse = 2'd1;
      rt_used = 1'b1; rt_tuse = 2'd2;
    end else if (lui | j | jal) begin
      rs_used = 1'b0;
      rt_used = 1'b0;
    end
  end

  always_comb begin
    id_tnew = 2'd0;
    if (alu_op)  id_tnew = 2'd1;
    else if (lw) id_tnew = 2'd2;
  end

  // Non-writing classes never carry a destination into the pipeline.
  assign id_a3 = writes ? A3_ID : 5'd0;

  function automatic logic hit(input logic [4:0] rd, input logic used, input logic [1:0] tuse,
                               input logic [4:0] a3, input logic [1:0] tnew);
    return used && (rd != 5'd0) && (a3 == rd) && (tnew > tuse);
  endfunction

  assign stall = hit(A1_ID, rs_used, rs_tuse, e_a3_q, e_tnew_q) |
                 hit(A1_ID, rs_used, rs_tuse, m_a3_q, m_tnew_q) |
                 hit(A2_ID, rt_used, rt_tuse, e_a3_q, e_tnew_q) |
                 hit(A2_ID, rt_used, rt_tuse, m_a3_q, m_tnew_q);

  function automatic logic [1:0] sel_id(input logic [4:0] rd);
    if (rd == 5'd0)                             return 2'd0;
    else if (e_a3_q == rd && e_tnew_q == 2'd0) return 2'd3;
    else if (m_a3_q == rd && m_tnew_q == 2'd0) return 2'd2;
    else if (w_a3_q == rd)                      return 2'd1;
    else                                        return 2'd0;
  endfunction

  function automatic logic [1:0] sel_e(input logic [4:0] rd);
    if (rd == 5'd0)                             return 2'd0;
    else if (m_a3_q == rd && m_tnew_q == 2'd0) return 2'd2;
    else if (w_a3_q == rd)                      return 2'd1;
    else                                        return 2'd0;
  endfunction

  assign fwd_rs_ID = sel_id(A1_ID);
  assign fwd_rt_ID = sel_id(A2_ID);
  assign fwd_rs_E  = sel_e(e_a1_q);
  assign fwd_rt_E  = sel_e(e_a2_q);
  assign fwd_rt_M  = (m_a2_q != 5'd0) && (w_a3_q == m_a2_q);

  always_comb begin
    w_a3_d   = m_a3_q;
    m_a2_d   = e_a2_q;
    m_a3_d   = e_a3_q;
    m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
    e_a1_d   = A1_ID;
    e_a2_d   = A2_ID;
    e_a3_d   = id_a3;
    e_tnew_d = id_tnew;
    if (stall) begin
      e_a1_d   = 5'd0;
      e_a2_d   = 5'd0;
      e_a3_d   = 5'd0;
      e_tnew_d = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_a1_q   <= 5'd0;
      e_a2_q   <= 5'd0;
      e_a3_q   <= 5'd0;
      e_tnew_q <= 2'd0;
      m_a2_q   <= 5'd0;
      m_a3_q   <= 5'd0;
      m_tnew_q <= 2'd0;
      w_a3_q   <= 5'd0;
    end else begin
      e_a1_q   <= e_a1_d;
      e_a2_q   <= e_a2_d;
      e_a3_q   <= e_a3_d;
      e_tnew_q <= e_tnew_d;
      m_a2_q   <= m_a2_d;
      m_a3_q   <= m_a3_d;
      m_tnew_q <= m_tnew_d;
      w_a3_q   <= w_a3_d;
    end
  end

endmodule
